// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions.
//   LS_*          : funct3 load/store width codes as latched in EX/ME.
//   dmem_state_t  : data-memory controller FSM states.
package riscv_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWaitR = 2'd2,
    StDone  = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for load/store units (purely combinational).
//   ls_type_i    : funct3 width code (unknown codes behave as W)
//   addr_lo_i    : byte offset within the word
//   wdata_i      : right-justified store data
//   rdata_i      : raw read word from the bus
//   be_o         : byte enables for the store
//   wdata_o      : store data replicated onto every lane
//   rdata_o      : selected lane, sign- or zero-extended
//   misaligned_o : access crosses its natural alignment
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  ls_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        zext;

  // funct3[2] marks the unsigned variants (BU/HU)
  assign zext = ls_type_i[2];

  always_comb begin
    unique case (addr_lo_i)
      2'd0: rbyte = rdata_i[7:0];
      2'd1: rbyte = rdata_i[15:8];
      2'd2: rbyte = rdata_i[23:16];
      2'd3: rbyte = rdata_i[31:24];
    endcase
    rhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = wdata_i;
    rdata_o      = rdata_i;
    misaligned_o = |addr_lo_i;
    case (ls_type_i)
      LS_B, LS_BU: begin
        be_o         = 4'b0001 << addr_lo_i;
        wdata_o      = {4{wdata_i[7:0]}};
        rdata_o      = {{24{rbyte[7] & ~zext}}, rbyte};
        misaligned_o = 1'b0;
      end
      LS_H, LS_HU: begin
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{16{rhalf[15] & ~zext}}, rhalf};
        misaligned_o = addr_lo_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage data-memory access controller.
// Runs one request/grant(/response) transaction per load or store in ME,
// holding the pipeline with stall_M until the access retires.
//   clk, rst           : core clock, asynchronous active-high reset
//   we_mem_M, re_mem_M : store / load in ME (store wins if both)
//   ls_type_M          : funct3 width code
//   addr_M             : byte address
//   write_data_M       : right-justified store data
//   dm_req/we/addr/be/wdata : registered bus request fields
//   dm_gnt, dm_rvalid, dm_rdata : bus responses
//   stall_M            : pipeline hold (combinational)
//   load_data_M        : extended load result (registered)
//   misalign           : misaligned-access pulse (combinational)
//   bus_err            : timeout pulse (registered)
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_mem_M,
  input  logic        re_mem_M,
  input  logic [2:0]  ls_type_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] write_data_M,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        stall_M,
  output logic [31:0] load_data_M,
  output logic        misalign,
  output logic        bus_err
);

  // One spare bit so the counter can pass TIMEOUT without wrapping
  localparam int unsigned CntW = $clog2(TIMEOUT + 2);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  dmem_state_t     state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      ls_type_q;
  logic [1:0]      off_q;
  logic            dm_req_q;
  logic            dm_we_q;
  logic [31:0]     dm_addr_q;
  logic [3:0]      dm_be_q;
  logic [31:0]     dm_wdata_q;
  logic [31:0]     load_data_q;
  logic            bus_err_q;

  logic            access;
  logic [2:0]      align_type;
  logic [1:0]      align_off;
  logic [3:0]      align_be;
  logic [31:0]     align_wdata;
  logic [31:0]     align_ext;
  logic            align_mis;
  logic [CntW-1:0] cnt_inc;
  logic            timeout_hit;

  assign access = we_mem_M | re_mem_M;

  // In IDLE the aligner decodes the live ME fields for capture; afterwards it
  // works from the captured type/offset so load extension ignores addr_M.
  assign align_type = (state_q == StIdle) ? ls_type_M   : ls_type_q;
  assign align_off  = (state_q == StIdle) ? addr_M[1:0] : off_q;

  lsu_align u_align (
    .ls_type_i    (align_type),
    .addr_lo_i    (align_off),
    .wdata_i      (write_data_M),
    .rdata_i      (dm_rdata),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .rdata_o      (align_ext),
    .misaligned_o (align_mis)
  );

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc >= TimeoutVal);

  // Gated by rst so the hold releases immediately on an asynchronous reset
  always_comb begin
    stall_M  = 1'b0;
    misalign = 1'b0;
    if (!rst) begin
      case (state_q)
        StIdle: begin
          if (access) begin
            stall_M  = ~align_mis;
            misalign = align_mis;
          end
        end
        StReq, StWaitR: stall_M = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ls_type_q   <= '0;
      off_q       <= '0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_be_q     <= '0;
      dm_wdata_q  <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (access) begin
            if (align_mis) begin
              load_data_q <= '0;
            end else begin
              state_q    <= StReq;
              cnt_q      <= '0;
              dm_req_q   <= 1'b1;
              dm_we_q    <= we_mem_M;
              ls_type_q  <= ls_type_M;
              off_q      <= addr_M[1:0];
              dm_addr_q  <= {addr_M[31:2], 2'b00};
              dm_be_q    <= align_be;
              dm_wdata_q <= align_wdata;
            end
          end
        end
        StReq: begin
          // A grant on the last allowed cycle still wins over the timeout
          if (dm_gnt) begin
            dm_req_q <= 1'b0;
            cnt_q    <= cnt_inc;
            state_q  <= dm_we_q ? StDone : StWaitR;
          end else if (timeout_hit) begin
            dm_req_q    <= 1'b0;
            bus_err_q   <= 1'b1;
            load_data_q <= '0;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWaitR: begin
          if (dm_rvalid) begin
            load_data_q <= align_ext;
            state_q     <= StDone;
          end else if (timeout_hit) begin
            bus_err_q   <= 1'b1;
            load_data_q <= '0;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;  // StDone: pipeline advances this edge
      endcase
    end
  end

  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_be       = dm_be_q;
  assign dm_wdata    = dm_wdata_q;
  assign load_data_M = load_data_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_mem_M, re_mem_M;
  logic [2:0]  ls_type_M;
  logic [31:0] addr_M, write_data_M;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        stall_M, misalign, bus_err;
  logic [31:0] load_data_M;

  dmem_ctrl #(.TIMEOUT(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .we_mem_M     (we_mem_M),
    .re_mem_M     (re_mem_M),
    .ls_type_M    (ls_type_M),
    .addr_M       (addr_M),
    .write_data_M (write_data_M),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_be        (dm_be),
    .dm_wdata     (dm_wdata),
    .dm_gnt       (dm_gnt),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .stall_M      (stall_M),
    .load_data_M  (load_data_M),
    .misalign     (misalign),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Observations from the most recent run_access
  int          r_stall, r_req_rise, r_req_cyc, r_misal, r_err;
  logic        r_we, r_done;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_ld;

  // Holds one instruction in ME until stall_M drops and plays the bus side.
  // gnt_dly: REQ cycles before grant (negative = never); rv_dly: cycles after
  // the grant cycle until rvalid.
  task automatic run_access(input logic we, input logic re, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int gnt_dly, input int rv_dly);
    logic granted = 1'b0;
    int   since   = 0;
    logic prev_req;
    r_stall = 0; r_req_rise = 0; r_req_cyc = 0; r_misal = 0; r_err = 0;
    r_we = 1'b0; r_be = '0; r_addr = '0; r_wdata = '0; r_ld = '0; r_done = 1'b0;
    prev_req = dm_req;
    for (int c = 0; c < 40 && !r_done; c++) begin
      @(negedge clk);
      we_mem_M = we; re_mem_M = re; ls_type_M = t; addr_M = a; write_data_M = wd;
      dm_rdata  = rd;
      dm_gnt    = dm_req && (gnt_dly >= 0) && (r_req_cyc == gnt_dly);
      dm_rvalid = granted && re && !we && (since == rv_dly);
      #1;
      if (stall_M)  r_stall++;
      if (misalign) r_misal++;
      if (bus_err)  r_err++;
      if (dm_req) begin
        r_req_cyc++;
        if (!prev_req) begin
          r_req_rise++;
          r_we = dm_we; r_be = dm_be; r_addr = dm_addr; r_wdata = dm_wdata;
        end
      end
      prev_req = dm_req;
      r_ld     = load_data_M;
      r_done   = !stall_M;
      @(posedge clk);
      if (granted) since++;
      if (dm_gnt) begin
        granted = 1'b1;
        since   = 1;
      end
    end
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    check("retire_bound", 32'(r_done), 32'd1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    we_mem_M = 1'b0; re_mem_M = 1'b0; ls_type_M = LS_W; addr_M = '0; write_data_M = '0;
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] exp_ld, input logic [3:0] exp_be);
    run_access(1'b0, 1'b1, t, a, 32'h0, 32'h80F1_7F00, 0, 1);
    check({tag, "_ld"},    r_ld, exp_ld);
    check({tag, "_be"},    32'(r_be), 32'(exp_be));
    check({tag, "_stall"}, 32'(r_stall), 32'd3);
    check({tag, "_we"},    32'(r_we), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    we_mem_M = 1'b0; re_mem_M = 1'b0; ls_type_M = LS_W; addr_M = '0; write_data_M = '0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req",   32'(dm_req), 32'd0);
    check("rst_stall", 32'(stall_M), 32'd0);
    check("rst_ld",    load_data_M, 32'd0);
    check("rst_addr",  dm_addr, 32'd0);
    check("rst_be",    32'(dm_be), 32'd0);
    check("rst_err",   32'(bus_err), 32'd0);
    rst = 1'b0;

    // SB 0x1003
    run_access(1'b1, 1'b0, LS_B, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0);
    check("sb_be",    32'(r_be), 32'h8);
    check("sb_wdata", r_wdata, 32'hA5A5_A5A5);
    check("sb_addr",  r_addr, 32'h0000_1000);
    check("sb_we",    32'(r_we), 32'd1);
    check("sb_stall", 32'(r_stall), 32'd2);
    check("sb_reqs",  32'(r_req_rise), 32'd1);

    do_load("lb",  LS_B,  32'h0000_2002, 32'hFFFF_FFF1, 4'b0100);
    check("lb_addr", r_addr, 32'h0000_2000);
    do_load("lhu", LS_HU, 32'h0000_2002, 32'h0000_80F1, 4'b1100);
    do_load("lh",  LS_H,  32'h0000_2000, 32'h0000_7F00, 4'b0011);
    do_load("lbu", LS_BU, 32'h0000_2003, 32'h0000_0080, 4'b1000);

    // Load and store together: store wins
    run_access(1'b1, 1'b1, LS_H, 32'h0000_7002, 32'h0000_BEEF, 32'h0, 0, 0);
    check("sh_we",    32'(r_we), 32'd1);
    check("sh_be",    32'(r_be), 32'hC);
    check("sh_wdata", r_wdata, 32'hBEEF_BEEF);
    check("sh_stall", 32'(r_stall), 32'd2);

    // LW misaligned
    run_access(1'b0, 1'b1, LS_W, 32'h0000_3002, 32'h0, 32'h0, 0, 1);
    check("mis_pulse", 32'(r_misal), 32'd1);
    check("mis_stall", 32'(r_stall), 32'd0);
    check("mis_reqs",  32'(r_req_rise), 32'd0);
    idle_cycle();
    check("mis_req_after", 32'(dm_req), 32'd0);
    check("mis_ld_zero",   load_data_M, 32'd0);

    do_load("lb3", LS_B, 32'h0000_2003, 32'hFFFF_FF80, 4'b1000);

    // Reset while in WAIT_R
    @(negedge clk);
    we_mem_M = 1'b0; re_mem_M = 1'b1; ls_type_M = LS_W; addr_M = 32'h0000_4000;
    @(posedge clk);
    @(negedge clk);
    dm_gnt = 1'b1;
    #1;
    check("wr_req_pre", 32'(dm_req), 32'd1);
    @(posedge clk);
    dm_gnt = 1'b0;
    @(negedge clk);
    #1;
    check("wr_stall_pre", 32'(stall_M), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("wr_rst_stall", 32'(stall_M), 32'd0);
    check("wr_rst_req",   32'(dm_req), 32'd0);
    check("wr_rst_ld",    load_data_M, 32'd0);
    check("wr_rst_addr",  dm_addr, 32'd0);
    idle_cycle();
    rst = 1'b0;
    run_access(1'b1, 1'b0, LS_W, 32'h0000_6000, 32'h1122_3344, 32'h0, 0, 0);
    check("rec_stall", 32'(r_stall), 32'd2);
    check("rec_be",    32'(r_be), 32'hF);
    check("rec_wdata", r_wdata, 32'h1122_3344);
    check("rec_addr",  r_addr, 32'h0000_6000);

    // SW with grant withheld: 8 REQ cycles then abort
    run_access(1'b1, 1'b0, LS_W, 32'h0000_9000, 32'hCAFE_F00D, 32'h0, -1, 0);
    check("to_req_cyc", 32'(r_req_cyc), 32'd8);
    check("to_stall",   32'(r_stall), 32'd9);
    check("to_err",     32'(r_err), 32'd1);
    check("to_reqs",    32'(r_req_rise), 32'd1);
    idle_cycle();
    check("to_err_after", 32'(bus_err), 32'd0);
    check("to_req_after", 32'(dm_req), 32'd0);

    // Back-to-back LW then SW, grant delayed 2 cycles each
    run_access(1'b0, 1'b1, LS_W, 32'h0000_5000, 32'h0, 32'h1234_5678, 2, 1);
    check("b2b_lw_reqs",  32'(r_req_rise), 32'd1);
    check("b2b_lw_rcyc",  32'(r_req_cyc), 32'd3);
    check("b2b_lw_we",    32'(r_we), 32'd0);
    check("b2b_lw_ld",    r_ld, 32'h1234_5678);
    check("b2b_lw_stall", 32'(r_stall), 32'd5);
    run_access(1'b1, 1'b0, LS_W, 32'h0000_5004, 32'hDEAD_BEEF, 32'h0, 2, 0);
    check("b2b_sw_reqs",  32'(r_req_rise), 32'd1);
    check("b2b_sw_rcyc",  32'(r_req_cyc), 32'd3);
    check("b2b_sw_we",    32'(r_we), 32'd1);
    check("b2b_sw_addr",  r_addr, 32'h0000_5004);
    check("b2b_sw_wdata", r_wdata, 32'hDEAD_BEEF);
    check("b2b_sw_stall", 32'(r_stall), 32'd4);
    idle_cycle();
    check("b2b_idle_req", 32'(dm_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
